vga_pixel_gen: RTL and testbench

Pixel generation stage directly downstream of the VGA timing generator. It consumes the free-running horizontal/vertical counters and sync pulses, and produces registered 3-bit-per-channel RGB for the lane background and the player sprite. It delays HSYNC/VSYNC to stay aligned with the pixel pipeline. Player position is shadow-latched once per frame at the start of vertical blanking, so the displayed frame never tears.

---
 rtl/vga_pixel_gen.sv | 158 +++++++++++++++
 tb/tb_vga_pixel_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_gen.sv
// vga_pixel_gen
// Pixel generation stage behind the VGA timing generator. A two-stage pipeline turns the
// free-running h/v counters into registered 3-bit RGB. The lane background is drawn per
// 32x32 cell row. The player sprite is drawn as one full cell. HSYNC/VSYNC are delayed by the
// same two stages so sync and colour stay aligned. The player position is shadow-latched at the
// start of vertical blanking, so a visible frame never mixes two positions.
//
// Ports:
//   CLK, RST_N           pixel clock, asynchronous active-low reset
//   h_count, v_count     counters from the timing generator
//   hs_in, vs_in         syncs aligned with the counters
//   player_x, player_y   requested player cell (same clock domain)
//   VGA_HS, VGA_VS       syncs delayed by 2 cycles
//   VGA_R, VGA_G, VGA_B  pixel colour, 3 bits per channel
//   frame_tick           1-cycle pulse, one cycle after the blanking-start counter values
//   frame_count          frames completed, wraps at 256
module vga_pixel_gen #(
   parameter int unsigned H_DISPLAY  = 640,
   parameter int unsigned V_DISPLAY  = 480,
   parameter int unsigned CELL_SHIFT = 5,
   parameter int unsigned GRID_W     = 20,
   parameter int unsigned GRID_H     = 15,
   parameter int unsigned START_X    = 9,
   parameter int unsigned START_Y    = 14
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [9:0] h_count,
   input  logic [9:0] v_count,
   input  logic       hs_in,
   input  logic       vs_in,
   input  logic [4:0] player_x,
   input  logic [3:0] player_y,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic [2:0] VGA_R,
   output logic [2:0] VGA_G,
   output logic [2:0] VGA_B,
   output logic       frame_tick,
   output logic [7:0] frame_count
);

   localparam int unsigned CellW = 10 - CELL_SHIFT;

   localparam logic [9:0] HDisp    = 10'(H_DISPLAY);
   localparam logic [9:0] VDisp    = 10'(V_DISPLAY);
   localparam logic [4:0] GridW    = 5'(GRID_W);
   localparam logic [3:0] GridH    = 4'(GRID_H);
   localparam logic [9:0] LastRow  = 10'(GRID_H - 1);
   localparam logic [4:0] StartX   = 5'(START_X);
   localparam logic [3:0] StartY   = 4'(START_Y);

   // Stage 1
   logic             active_q;
   logic [CellW-1:0] cell_x_q;
   logic [CellW-1:0] cell_y_q;
   logic             hs1_q;
   logic             vs1_q;

   // Stage 2 / outputs
   logic [2:0] r_q, r_d;
   logic [2:0] g_q, g_d;
   logic [2:0] b_q, b_d;
   logic       hs2_q;
   logic       vs2_q;

   // Shadow position and frame bookkeeping
   logic [4:0] px_q, px_d;
   logic [3:0] py_q, py_d;
   logic       tick_q;
   logic [7:0] fcount_q, fcount_d;

   logic active_d;
   logic boundary;
   logic in_range;
   logic is_player;

   always_comb begin
      active_d  = (h_count < HDisp) && (v_count < VDisp);
      boundary  = (h_count == '0) && (v_count == VDisp);
      in_range  = (player_x < GridW) && (player_y < GridH);

      // Out-of-range requests keep both shadow coordinates, never a half update.
      px_d     = px_q;
      py_d     = py_q;
      fcount_d = fcount_q;
      if (boundary) begin
         fcount_d = fcount_q + 8'd1;
         if (in_range) begin
            px_d = player_x;
            py_d = player_y;
         end
      end

      is_player = (10'(cell_x_q) == 10'(px_q)) && (10'(cell_y_q) == 10'(py_q));

      r_d = '0;
      g_d = '0;
      b_d = '0;
      if (active_q) begin
         if (is_player) begin
            r_d = 3'd7;
            g_d = 3'd7;
         end else if ((cell_y_q == '0) || (10'(cell_y_q) == LastRow)) begin
            g_d = 3'd7;
         end else if (cell_y_q[0]) begin
            r_d = 3'd2;
            g_d = 3'd2;
            b_d = 3'd2;
         end else begin
            b_d = 3'd3;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         active_q <= 1'b0;
         cell_x_q <= '0;
         cell_y_q <= '0;
         hs1_q    <= 1'b0;
         vs1_q    <= 1'b0;
         r_q      <= '0;
         g_q      <= '0;
         b_q      <= '0;
         hs2_q    <= 1'b0;
         vs2_q    <= 1'b0;
         px_q     <= StartX;
         py_q     <= StartY;
         tick_q   <= 1'b0;
         fcount_q <= '0;
      end else begin
         active_q <= active_d;
         cell_x_q <= h_count[9:CELL_SHIFT];
         cell_y_q <= v_count[9:CELL_SHIFT];
         hs1_q    <= hs_in;
         vs1_q    <= vs_in;
         r_q      <= r_d;
         g_q      <= g_d;
         b_q      <= b_d;
         hs2_q    <= hs1_q;
         vs2_q    <= vs1_q;
         px_q     <= px_d;
         py_q     <= py_d;
         tick_q   <= boundary;
         fcount_q <= fcount_d;
      end
   end

   assign VGA_R       = r_q;
   assign VGA_G       = g_q;
   assign VGA_B       = b_q;
   assign VGA_HS      = hs2_q;
   assign VGA_VS      = vs2_q;
   assign frame_tick  = tick_q;
   assign frame_count = fcount_q;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Self-checking bench for vga_pixel_gen: a frame-level colour model checked every cycle,
// plus literal probes for the sprite, lanes, shadow latch, range check, wrap and reset.
module tb_vga_pixel_gen;

   localparam logic [8:0] Black  = 9'b000_000_000;
   localparam logic [8:0] Yellow = 9'b111_111_000;
   localparam logic [8:0] Green  = 9'b000_111_000;
   localparam logic [8:0] Grey   = 9'b010_010_010;
   localparam logic [8:0] Blue   = 9'b000_000_011;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b1;
   logic [9:0] h_count = '0;
   logic [9:0] v_count = '0;
   logic       hs_in = 1'b0;
   logic       vs_in = 1'b0;
   logic [4:0] player_x = 5'd9;
   logic [3:0] player_y = 4'd14;
   logic       VGA_HS, VGA_VS, frame_tick;
   logic [2:0] VGA_R, VGA_G, VGA_B;
   logic [7:0] frame_count;

   vga_pixel_gen dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .h_count     (h_count),
      .v_count     (v_count),
      .hs_in       (hs_in),
      .vs_in       (vs_in),
      .player_x    (player_x),
      .player_y    (player_y),
      .VGA_HS      (VGA_HS),
      .VGA_VS      (VGA_VS),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B),
      .frame_tick  (frame_tick),
      .frame_count (frame_count)
   );

   always #20 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int         sh_x, sh_y, fcount;
   logic [8:0] prev_col, exp_col;
   bit         prev_hs, prev_vs, exp_hs, exp_vs, exp_tick;

   function automatic logic [8:0] colour(input int h, input int v, input int sx, input int sy);
      int cx;
      int cy;
      if (h >= 640 || v >= 480) return Black;
      cx = h / 32;
      cy = v / 32;
      if (cx == sx && cy == sy) return Yellow;
      if (cy == 0 || cy == 14) return Green;
      if (cy % 2 == 1) return Grey;
      return Blue;
   endfunction

   task automatic model_reset();
      sh_x = 9; sh_y = 14; fcount = 0;
      prev_col = Black; exp_col = Black;
      prev_hs = 0; prev_vs = 0; exp_hs = 0; exp_vs = 0; exp_tick = 0;
   endtask

   // Called at each rising edge with the inputs the DUT just sampled.
   task automatic model_step();
      bit bnd;
      if (!RST_N) begin
         model_reset();
         return;
      end
      exp_col = prev_col;
      exp_hs  = prev_hs;
      exp_vs  = prev_vs;
      bnd = (h_count == 10'd0) && (v_count == 10'd480);
      exp_tick = bnd;
      if (bnd) begin
         fcount = (fcount + 1) % 256;
         if (player_x < 20 && player_y < 15) begin
            sh_x = player_x;
            sh_y = player_y;
         end
      end
      prev_col = colour(h_count, v_count, sh_x, sh_y);
      prev_hs  = hs_in;
      prev_vs  = vs_in;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t h=%0d v=%0d)", name, act, exp, $time,
                  h_count, v_count);
      end
   endtask

   task automatic compare_all();
      check("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(exp_col));
      check("hs", 32'(VGA_HS), 32'(exp_hs));
      check("vs", 32'(VGA_VS), 32'(exp_vs));
      check("tick", 32'(frame_tick), 32'(exp_tick));
      check("fcount", 32'(frame_count), 32'(fcount));
   endtask

   // Drive one cycle of counters, step the model on the edge, compare mid-cycle.
   task automatic cyc(input int h, input int v, input bit hs, input bit vs);
      h_count = 10'(h);
      v_count = 10'(v);
      hs_in   = hs;
      vs_in   = vs;
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      compare_all();
   endtask

   task automatic probe(input string name, input int h, input int v, input logic [8:0] want);
      cyc(h, v, 1, 1);
      cyc(0, 500, 1, 1);
      check(name, 32'({VGA_R, VGA_G, VGA_B}), 32'(want));
   endtask

   task automatic check_zero(input string name);
      check({name, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
      check({name, "_hs"}, 32'(VGA_HS), 32'd0);
      check({name, "_vs"}, 32'(VGA_VS), 32'd0);
      check({name, "_tick"}, 32'(frame_tick), 32'd0);
      check({name, "_fc"}, 32'(frame_count), 32'd0);
   endtask

   initial begin
      model_reset();
      #1 RST_N = 1'b0;
      #2 check_zero("rst_init");
      @(negedge CLK);
      @(negedge CLK);
      check_zero("rst_held");
      RST_N = 1'b1;

      // Two free-running lines crossing into the sprite row, HSYNC low in its pulse window.
      for (int v = 447; v <= 448; v++)
         for (int h = 0; h < 800; h++)
            cyc(h, v, !(h >= 656 && h < 752), 1);

      probe("sprite_tl", 288, 448, Yellow);
      probe("sprite_br", 319, 479, Yellow);
      probe("left_of_sprite", 287, 448, Green);
      probe("right_of_sprite", 320, 448, Green);
      probe("blank_h", 640, 100, Black);
      probe("row1_grey", 0, 32, Grey);
      probe("row2_blue", 0, 64, Blue);
      probe("goal_row", 100, 5, Green);

      // Mid-frame request must not move the sprite until the boundary.
      cyc(0, 200, 1, 1);
      player_x = 5'd3;
      for (int h = 1; h < 40; h++) cyc(h, 200, 1, 1);
      probe("no_tear_old", 288, 460, Yellow);
      probe("no_tear_new", 96, 460, Green);
      cyc(0, 480, 1, 0);
      check("tick_high", 32'(frame_tick), 32'd1);
      check("fc_one", 32'(frame_count), 32'd1);
      cyc(1, 480, 1, 0);
      check("tick_low", 32'(frame_tick), 32'd0);
      probe("moved_new", 96, 460, Yellow);
      probe("moved_old", 288, 460, Green);

      // Out-of-range requests hold both coordinates but still count the frame.
      player_x = 5'd25;
      cyc(0, 480, 1, 0);
      check("fc_two", 32'(frame_count), 32'd2);
      player_x = 5'd3;
      probe("range_x_hold", 96, 460, Yellow);
      player_x = 5'd5;
      player_y = 4'd15;
      cyc(0, 480, 1, 0);
      check("fc_three", 32'(frame_count), 32'd3);
      player_x = 5'd3;
      player_y = 4'd14;
      probe("range_y_hold", 96, 460, Yellow);
      probe("range_y_nox", 160, 460, Green);

      // 256 frames bring the counter back around.
      for (int i = 0; i < 256; i++) begin
         cyc(0, 480, 1, 0);
         cyc(7, 490, 1, 0);
      end
      check("fc_wrap", 32'(frame_count), 32'd3);

      // Sync delay.
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 1);
      check("hs_delay_hi", 32'(VGA_HS), 32'd1);
      check("vs_delay_lo", 32'(VGA_VS), 32'd0);
      cyc(0, 0, 0, 0);
      check("hs_delay_lo", 32'(VGA_HS), 32'd0);
      check("vs_delay_hi", 32'(VGA_VS), 32'd1);

      // Randomized traffic: counters, syncs, player requests and injected boundaries.
      for (int i = 0; i < 20000; i++) begin
         int h;
         int v;
         if ($urandom_range(0, 15) == 0) begin
            player_x = 5'($urandom_range(0, 31));
            player_y = 4'($urandom_range(0, 15));
         end
         h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 799) : $urandom_range(0, 639);
         v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 524) : $urandom_range(0, 479);
         if ($urandom_range(0, 63) == 0) begin
            h = 0;
            v = 480;
         end
         cyc(h, v, 1'($urandom), 1'($urandom));
      end

      // Asynchronous reset mid-line.
      player_x = 5'd3;
      player_y = 4'd14;
      cyc(0, 480, 1, 1);
      cyc(300, 200, 1, 1);
      cyc(300, 200, 1, 1);
      check("pre_rst_blue", 32'({VGA_R, VGA_G, VGA_B}), 32'(Blue));
      #5 RST_N = 1'b0;
      #1 check_zero("rst_async");
      model_reset();
      cyc(300, 200, 1, 1);
      cyc(301, 200, 1, 1);
      RST_N = 1'b1;
      probe("post_rst_home", 300, 460, Yellow);
      probe("post_rst_req", 96, 460, Green);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
